i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
Shares the single board I2C bus (SCL/SDA to the ADV7513 and camera) between several I2C transaction engines, such as the init sequencer and register reader. Each engine requests the bus, is granted exclusive ownership, and has its open-drain enables muxed onto the bus. A guard gap follows every release, and a watchdog reclaims the bus from a hung owner. It sits between the engines and the top-level I2C_SCL/I2C_SDA tristate drivers.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
GAP_CYCLES, 8'd16, bus-idle clk cycles enforced after every release; 0 means no gap.
TIMEOUT_CYCLES, 32'd1000000, maximum clk cycles one owner may hold the bus; 0 disables the watchdog.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
req  in  NUM_REQ  per-requester bus request; level, held until done.
done_in  in  NUM_REQ  per-requester transaction-complete pulse; only the owner's bit is honoured.
scl_oe_in  in  NUM_REQ  per-requester SCL pull-low enable.
sda_oe_in  in  NUM_REQ  per-requester SDA pull-low enable.
grant  out  NUM_REQ  one-hot grant, registered.
owner  out  2  index of the current or last owner, registered.
busy  out  1  high in GRANT or GAP state.
scl_oe  out  1  muxed SCL pull-low enable to the pad driver.
sda_oe  out  1  muxed SDA pull-low enable to the pad driver.
timeout  out  1  single-cycle pulse when the watchdog fires.
timeout_err  out  1  sticky watchdog flag; cleared only by reset.

Behaviour:
- States: IDLE, GRANT, GAP. Reset forces IDLE immediately (async).
- Reset values: grant=0, owner=NUM_REQ-1, busy=0, scl_oe=0, sda_oe=0, timeout=0, timeout_err=0; hold and gap counters=0.
- IDLE:
  - Any req bit high at a clk edge selects a winner.
  - Next edge: grant[winner]=1, owner=winner, busy=1, state=GRANT. Latency from req to grant is 1 cycle.
  - If no req, stay in IDLE.
- Winner selection is round-robin: search upward from (owner+1) mod NUM_REQ and wrap. After reset, req[0] wins first.
- GRANT:
  - scl_oe=scl_oe_in[owner] and sda_oe=sda_oe_in[owner], combinational with zero latency.
  - Non-owner oe and done_in inputs are ignored.
  - The hold counter increments every cycle in GRANT.
- Release conditions, evaluated each edge in GRANT:
  - (a) done_in[owner]=1;
  - (b) req[owner]=0;
  - (c) TIMEOUT_CYCLES!=0 and the hold counter reaches TIMEOUT_CYCLES-1, i.e. the owner has held the bus for TIMEOUT_CYCLES cycles.
- On release at the next edge:
  - grant=0; scl_oe=sda_oe=0, so the bus is released.
  - Enter GAP and clear the gap counter; if GAP_CYCLES=0, go directly to IDLE and clear busy.
- Watchdog release:
  - Only on condition (c) alone: timeout=1 for exactly one cycle, coincident with grant dropping; timeout_err set.
  - Conditions (a) or (b) occurring on the same edge take precedence, so timeout does not fire.
- GAP:
  - Bus outputs held at 0; grant=0; busy=1.
  - After exactly GAP_CYCLES cycles, enter IDLE with busy=0.
  - Requests arriving during GAP wait; they are served from IDLE with the 1-cycle latency.
- A requester dropping req before it is granted is simply not selected; there is no memory of past requests.
- A requester still asserting req after its own release re-competes. Round-robin gives any other pending requester priority.
- Arithmetic: the hold counter is 32-bit and saturates; it cannot wrap while the watchdog is disabled. The gap counter is 8-bit.
- Invariant: grant is always one-hot or zero; scl_oe and sda_oe are never driven from a non-owner.

Optional Feature:
I2C_ARB_FIXED_PRIO_EN:
- Defined: winner is the lowest-index asserted req bit, with no rotation. Intended so the init sequencer (index 0) always preempts readers at the next arbitration point; there is still no preemption mid-transaction.
- Undefined (default): round-robin as in Behaviour. All other behaviour is identical in both builds.

Test Plan:
Bench parameters: NUM_REQ=2, GAP_CYCLES=4, TIMEOUT_CYCLES=100.
1. Reset mid-GRANT: assert reset with grant=2'b01 and scl_oe=1 -> all outputs 0 asynchronously, before the next clk edge; after release, req=2'b01 wins again first.
2. Single request: req=2'b10 at edge N -> grant=2'b10, owner=1, busy=1 at N+1. Toggle scl_oe_in[1] -> scl_oe follows the same cycle. done_in[1] pulse -> grant=0 next edge, busy=1 for 4 cycles, then busy=0.
3. Simultaneous requests: req=2'b11 held, each owner pulsing done_in after 10 cycles -> grants alternate 01, 10, 01, with a 4-cycle gap between each. With I2C_ARB_FIXED_PRIO_EN defined -> grant stays 2'b01 every round.
4. Hung owner: req[0] held with no done_in -> after 100 cycles in GRANT, grant drops, timeout pulses for 1 cycle, and timeout_err stays 1 until reset.
5. Isolation: in GRANT with owner=0, drive scl_oe_in[1]=sda_oe_in[1]=1 and done_in[1]=1 -> scl_oe and sda_oe track requester 0 only; grant unchanged.
6. Edge cases: done_in[owner] on the exact timeout edge -> release with timeout=0. Requester drops req during GAP -> IDLE with no grant.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Shares one open-drain I2C bus between NUM_REQ transaction engines with a post-release gap and an owner watchdog.
// Optional build macro I2C_ARB_FIXED_PRIO_EN: lowest-index requester always wins instead of round-robin.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [7:0]  GAP_CYCLES     = 8'd16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done_in,
  input  logic [NUM_REQ-1:0] scl_oe_in,
  input  logic [NUM_REQ-1:0] sda_oe_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               scl_oe,
  output logic               sda_oe,
  output logic               timeout,
  output logic               timeout_err
);

  localparam int unsigned OWNER_W = 2;
  localparam int unsigned HOLD_W  = 32;
  localparam int unsigned GAP_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [OWNER_W-1:0]   r_owner;
  logic                 r_busy;
  logic                 r_timeout;
  logic                 r_timeout_err;
  logic [HOLD_W-1:0]    r_hold;
  logic [GAP_W-1:0]     r_gap;

  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic [OWNER_W-1:0]   w_owner_nxt;
  logic                 w_busy_nxt;
  logic                 w_timeout_nxt;
  logic                 w_timeout_err_nxt;
  logic [HOLD_W-1:0]    w_hold_nxt;
  logic [GAP_W-1:0]     w_gap_nxt;

  logic                 w_found;
  logic [OWNER_W-1:0]   w_winner;
  logic                 w_own_req;
  logic                 w_own_done;
  logic                 w_wd_hit;

  // The one-hot grant doubles as the owner select, so non-owners can never reach the pads.
  assign w_own_req  = |(req & r_grant);
  assign w_own_done = |(done_in & r_grant);
  assign w_wd_hit   = (TIMEOUT_CYCLES != 32'd0) && (r_hold == (TIMEOUT_CYCLES - 32'd1));

  assign scl_oe      = |(scl_oe_in & r_grant);
  assign sda_oe      = |(sda_oe_in & r_grant);
  assign grant       = r_grant;
  assign owner       = r_owner;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign timeout_err = r_timeout_err;

  // Winner search: scan NUM_REQ slots upward from the base index, wrapping once.
  always_comb begin
    int base;
    int idx;
    logic [NUM_REQ-1:0] mask;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    mask     = '0;
`ifdef I2C_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = int'(r_owner) + 1;
`endif
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = base + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      mask = NUM_REQ'(1) << idx;
      if (!w_found && (|(req & mask))) begin
        w_found  = 1'b1;
        w_winner = OWNER_W'(idx);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_owner_nxt       = r_owner;
    w_busy_nxt        = r_busy;
    w_timeout_nxt     = 1'b0;
    w_timeout_err_nxt = r_timeout_err;
    w_hold_nxt        = r_hold;
    w_gap_nxt         = r_gap;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = NUM_REQ'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = '0;
        end
      end

      S_GRANT: begin
        w_hold_nxt = (r_hold == {HOLD_W{1'b1}}) ? r_hold : (r_hold + HOLD_W'(1));
        if (w_own_done || !w_own_req || w_wd_hit) begin
          w_grant_nxt = '0;
          w_gap_nxt   = '0;
          // A normal completion on the watchdog edge is not a timeout.
          if (w_wd_hit && !w_own_done && w_own_req) begin
            w_timeout_nxt     = 1'b1;
            w_timeout_err_nxt = 1'b1;
          end
          if (GAP_CYCLES == 8'd0) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (r_gap == (GAP_CYCLES - 8'd1)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_owner       <= OWNER_W'(NUM_REQ - 1);
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_hold        <= '0;
      r_gap         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout     <= w_timeout_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_hold        <= w_hold_nxt;
      r_gap         <= w_gap_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_i2c_bus_arbiter;

  localparam int unsigned N  = 2;
  localparam int          GAP = 4;
  localparam int          TO  = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, done_in, scl_oe_in, sda_oe_in;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         busy, scl_oe, sda_oe, timeout, timeout_err;

  i2c_bus_arbiter #(
    .NUM_REQ       (N),
    .GAP_CYCLES    (8'd4),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done_in    (done_in),
    .scl_oe_in  (scl_oe_in),
    .sda_oe_in  (sda_oe_in),
    .grant      (grant),
    .owner      (owner),
    .busy       (busy),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .timeout    (timeout),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bus phase (0 free, 1 owned, 2 guard gap), who owns it, how long.
  int m_phase;
  int m_owner;
  int m_held;
  int m_gap_left;
  bit m_to;
  bit m_terr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  function automatic int pick();
`ifdef I2C_ARB_FIXED_PRIO_EN
    for (int i = 0; i < int'(N); i++)
      if (bitof(req, i)) return i;
`else
    for (int i = 1; i <= int'(N); i++)
      if (bitof(req, (m_owner + i) % int'(N))) return (m_owner + i) % int'(N);
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_phase    = 0;
    m_owner    = int'(N) - 1;
    m_held     = 0;
    m_gap_left = 0;
    m_to       = 1'b0;
    m_terr     = 1'b0;
  endtask

  task automatic model_step();
    bit a, b, c;
    m_to = 1'b0;
    case (m_phase)
      0: if (req != '0) begin
        m_owner = pick();
        m_phase = 1;
        m_held  = 0;
      end
      1: begin
        m_held++;
        a = bitof(done_in, m_owner);
        b = !bitof(req, m_owner);
        c = (TO != 0) && (m_held >= TO);
        if (a || b || c) begin
          if (c && !a && !b) begin
            m_to   = 1'b1;
            m_terr = 1'b1;
          end
          if (GAP == 0) m_phase = 0;
          else begin
            m_phase    = 2;
            m_gap_left = GAP;
          end
        end
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = 0;
      end
    endcase
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = (m_phase == 1) ? (N'(1) << m_owner) : '0;
    chk("grant",       32'(grant),       32'(eg));
    chk("owner",       32'(owner),       32'(m_owner));
    chk("busy",        32'(busy),        32'(m_phase != 0));
    chk("scl_oe",      32'(scl_oe),      32'((m_phase == 1) && bitof(scl_oe_in, m_owner)));
    chk("sda_oe",      32'(sda_oe),      32'((m_phase == 1) && bitof(sda_oe_in, m_owner)));
    chk("timeout",     32'(timeout),     32'(m_to));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    check_all();
  endtask

  task automatic drain();
    req     = '0;
    done_in = '0;
    repeat (8) tick();
  endtask

  initial begin
    logic [N-1:0] exp_g;
    reset     = 1'b1;
    req       = '0;
    done_in   = '0;
    scl_oe_in = '0;
    sda_oe_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // 1: async reset while owned, then requester 0 wins first again
    req       = 2'b01;
    scl_oe_in = 2'b01;
    repeat (2) tick();
    chk("pre_reset_scl", 32'(scl_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_scl",   32'(scl_oe), 32'd0);
    check_all();
    @(negedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("post_reset_first", 32'(grant), 32'b01);
    scl_oe_in = '0;
    drain();

    // 2: single request, zero-latency oe, done pulse and 4-cycle gap
    req = 2'b10;
    tick();
    scl_oe_in = 2'b10;
    #1;
    check_all();
    scl_oe_in = 2'b00;
    sda_oe_in = 2'b10;
    #1;
    check_all();
    sda_oe_in = '0;
    done_in = 2'b10;
    tick();
    done_in = '0;
    req     = '0;
    repeat (4) tick();
    chk("gap_end_busy", 32'(busy), 32'd0);

    // 3: both requesting, each owner finishes after 10 cycles
    req = 2'b11;
    tick();
    for (int r = 0; r < 4; r++) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("rr_grant", 32'(grant), 32'(exp_g));
      repeat (9) tick();
      done_in = N'(1) << m_owner;
      tick();
      done_in = '0;
      repeat (5) tick();
    end
    drain();

    // 4: hung owner, watchdog after 100 cycles
    req = 2'b01;
    tick();
    repeat (99) tick();
    chk("wd_still_owned", 32'(grant), 32'b01);
    tick();
    chk("wd_pulse", 32'(timeout), 32'd1);
    tick();
    chk("wd_pulse_end", 32'(timeout), 32'd0);
    chk("wd_sticky",    32'(timeout_err), 32'd1);
    drain();

    // 5: non-owner oe and done are ignored
    req = 2'b01;
    tick();
    scl_oe_in = 2'b10;
    sda_oe_in = 2'b10;
    done_in   = 2'b10;
    repeat (3) tick();
    chk("iso_grant", 32'(grant), 32'b01);
    chk("iso_scl",   32'(scl_oe), 32'd0);
    scl_oe_in = 2'b11;
    #1;
    check_all();
    scl_oe_in = '0;
    sda_oe_in = '0;
    drain();

    // 6: done on the exact watchdog edge, then a request dropped during the gap
    req = 2'b01;
    tick();
    repeat (99) tick();
    done_in = 2'b01;
    tick();
    chk("to_edge_no_pulse", 32'(timeout), 32'd0);
    done_in = '0;
    req     = 2'b10;
    repeat (2) tick();
    req = '0;
    repeat (4) tick();
    chk("drop_in_gap", 32'(grant), 32'd0);
    drain();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(63) == 0) req = req ^ (N'(1) << $urandom_range(N - 1));
      for (int b = 0; b < int'(N); b++) begin
        done_in = (done_in & ~(N'(1) << b)) | (N'($urandom_range(63) == 0) << b);
      end
      scl_oe_in = N'($urandom);
      sda_oe_in = N'($urandom);
      tick();
    end

    // Sticky flag clears only on reset
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
